elevator: RTL and testbench

ELEVATOR -- requirements
Module: elevator

---
 rtl/elevator_pkg.sv | 30 +++
 rtl/elevator_req_reg.sv | 48 ++++
 rtl/elevator.sv | 161 ++++++++++++++++
 tb/tb_elevator.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared types and defaults for the elevator controller.
// Holds the FSM state encoding, default sizing constants and the
// state-to-output decode used to register door/motion outputs.
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR      = 2'd3
  } state_t;

  localparam int DEF_FLOORS       = 8;
  localparam int DEF_FLOOR_CYCLES = 2;
  localparam int DEF_DOOR_CYCLES  = 3;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // {door_open, moving_up, moving_down} for a given state; at most one bit set.
  function automatic logic [2:0] state_outs(input state_t s);
    case (s)
      DOOR:      return 3'b100;
      MOVE_UP:   return 3'b010;
      MOVE_DOWN: return 3'b001;
      default:   return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/elevator_req_reg.sv
// Pending-call register with set/clear and position-relative summary flags.
// Ports: clk, rst (sync, active-low); floor_req call buttons; pos current floor;
//        in_door masks presses of pos; clr_en/clr_idx clear one call (wins over set);
//        req_q pending calls; any_above/any_below/here relative to pos.
module elevator_req_reg import elevator_pkg::*; #(
  parameter int FLOORS = DEF_FLOORS,
  parameter int POS_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLOORS-1:0] floor_req,
  input  logic [POS_W-1:0]  pos,
  input  logic              in_door,
  input  logic              clr_en,
  input  logic [POS_W-1:0]  clr_idx,
  output logic [FLOORS-1:0] req_q,
  output logic              any_above,
  output logic              any_below,
  output logic              here
);

  logic [FLOORS-1:0] set_v;
  logic [FLOORS-1:0] clr_v;

  always_comb begin
    set_v = floor_req;
    // A press of the floor whose door is already open is never latched.
    if (in_door) set_v[pos] = 1'b0;
    clr_v = '0;
    if (clr_en) clr_v[clr_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) req_q <= '0;
    else      req_q <= (req_q | set_v) & ~clr_v;
  end

  always_comb begin
    any_above = 1'b0;
    any_below = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if (req_q[i] && (i > int'(pos))) any_above = 1'b1;
      if (req_q[i] && (i < int'(pos))) any_below = 1'b1;
    end
    here = req_q[pos];
  end

endmodule

// File: rtl/elevator.sv
// Single-car elevator controller serving calls in SCAN (collective) order.
// Ports: clk, rst (sync, active-low); floor_req call buttons; floor_pos current
//        floor; door_open, moving_up, moving_down registered status outputs.
// Optional: define ELEVATOR_DOOR_HOLD_EN so a press of the current floor while
//        the door is open restarts the door timer.
module elevator import elevator_pkg::*; #(
  parameter int FLOORS       = DEF_FLOORS,
  parameter int POS_W        = 3,
  parameter int FLOOR_CYCLES = DEF_FLOOR_CYCLES,
  parameter int DOOR_CYCLES  = DEF_DOOR_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLOORS-1:0] floor_req,
  output logic [POS_W-1:0]  floor_pos,
  output logic              door_open,
  output logic              moving_up,
  output logic              moving_down
);

  localparam int MAXC = (FLOOR_CYCLES > DOOR_CYCLES) ? FLOOR_CYCLES : DOOR_CYCLES;
  localparam int TW   = $clog2(MAXC + 1);

  state_t            state;
  logic              dir;
  logic [TW-1:0]     timer;
  logic [FLOORS-1:0] req_q;
  logic              any_above, any_below, here;
  logic              clr_en;
  logic [POS_W-1:0]  clr_idx;
  logic [POS_W-1:0]  pos_up, pos_dn;
  logic              leg_done, door_done, hit_up, hit_dn, hold;

  assign pos_up    = floor_pos + POS_W'(1);
  assign pos_dn    = floor_pos - POS_W'(1);
  assign leg_done  = (timer == TW'(FLOOR_CYCLES - 1));
  assign door_done = (timer == TW'(DOOR_CYCLES - 1));
  // Call at the floor about to be reached; only meaningful while moving, where
  // a neighbour in the travel direction is guaranteed to exist.
  assign hit_up    = req_q[pos_up];
  assign hit_dn    = req_q[pos_dn];

`ifdef ELEVATOR_DOOR_HOLD_EN
  assign hold = (state == DOOR) && floor_req[floor_pos];
`else
  assign hold = 1'b0;
`endif

  // Clear the call of the floor whose door opens on this edge.
  always_comb begin
    clr_en  = 1'b0;
    clr_idx = floor_pos;
    case (state)
      IDLE:      clr_en = here;
      MOVE_UP:   begin clr_en = leg_done && hit_up; clr_idx = pos_up; end
      MOVE_DOWN: begin clr_en = leg_done && hit_dn; clr_idx = pos_dn; end
      default:   clr_en = 1'b0;
    endcase
  end

  elevator_req_reg #(.FLOORS(FLOORS), .POS_W(POS_W)) u_req (
    .clk       (clk),
    .rst       (rst),
    .floor_req (floor_req),
    .pos       (floor_pos),
    .in_door   (state == DOOR),
    .clr_en    (clr_en),
    .clr_idx   (clr_idx),
    .req_q     (req_q),
    .any_above (any_above),
    .any_below (any_below),
    .here      (here)
  );

  // When a leg ends without a stop, the arrived-at floor holds no call, so the
  // flags relative to the old floor still describe "calls ahead" correctly.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      floor_pos <= '0;
      timer     <= '0;
      dir       <= DIR_UP;
      {door_open, moving_up, moving_down} <= 3'b000;
    end else begin
      case (state)
        IDLE: begin
          timer <= '0;
          if (here) begin
            state <= DOOR;
            {door_open, moving_up, moving_down} <= state_outs(DOOR);
          end else if (any_above) begin
            state <= MOVE_UP;
            dir   <= DIR_UP;
            {door_open, moving_up, moving_down} <= state_outs(MOVE_UP);
          end else if (any_below) begin
            state <= MOVE_DOWN;
            dir   <= DIR_DOWN;
            {door_open, moving_up, moving_down} <= state_outs(MOVE_DOWN);
          end
        end
        MOVE_UP: begin
          if (leg_done) begin
            floor_pos <= pos_up;
            timer     <= '0;
            if (hit_up) begin
              state <= DOOR;
              {door_open, moving_up, moving_down} <= state_outs(DOOR);
            end else if (!any_above) begin
              state <= IDLE;
              {door_open, moving_up, moving_down} <= state_outs(IDLE);
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        MOVE_DOWN: begin
          if (leg_done) begin
            floor_pos <= pos_dn;
            timer     <= '0;
            if (hit_dn) begin
              state <= DOOR;
              {door_open, moving_up, moving_down} <= state_outs(DOOR);
            end else if (!any_below) begin
              state <= IDLE;
              {door_open, moving_up, moving_down} <= state_outs(IDLE);
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        DOOR: begin
          if (hold) begin
            timer <= '0;
          end else if (door_done) begin
            timer <= '0;
            if ((dir == DIR_UP && any_above) || (dir == DIR_DOWN && !any_below && any_above)) begin
              state <= MOVE_UP;
              dir   <= DIR_UP;
              {door_open, moving_up, moving_down} <= state_outs(MOVE_UP);
            end else if (any_below) begin
              state <= MOVE_DOWN;
              dir   <= DIR_DOWN;
              {door_open, moving_up, moving_down} <= state_outs(MOVE_DOWN);
            end else begin
              state <= IDLE;
              {door_open, moving_up, moving_down} <= state_outs(IDLE);
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: begin
          state <= IDLE;
          timer <= '0;
          {door_open, moving_up, moving_down} <= state_outs(IDLE);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_elevator.sv
// Testbench for elevator: output runs {floor, door, up, down} are collected by a
// monitor and matched against expected runs queued by the stimulus process.
module tb_elevator;
  localparam int FLOORS = 8;
  localparam int POS_W  = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [FLOORS-1:0] floor_req = '0;
  logic [POS_W-1:0]  floor_pos;
  logic              door_open, moving_up, moving_down;

  int n_cmp = 0;
  int n_bad = 0;

  // tup = {floor_pos, door_open, moving_up, moving_down}; len 0 = any length
  typedef struct {
    logic [5:0] tup;
    int         len;
  } seg_t;
  seg_t exp_q[$];

  elevator #(.FLOORS(FLOORS), .POS_W(POS_W), .FLOOR_CYCLES(2), .DOOR_CYCLES(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .floor_req   (floor_req),
    .floor_pos   (floor_pos),
    .door_open   (door_open),
    .moving_up   (moving_up),
    .moving_down (moving_down)
  );

  always #5 clk = ~clk;

  task automatic expect_seg(input int p, input logic d, input logic u, input logic dn, input int len);
    seg_t s;
    s.tup = {POS_W'(p), d, u, dn};
    s.len = len;
    exp_q.push_back(s);
  endtask

  task automatic exp_up(input int p);               expect_seg(p, 1'b0, 1'b1, 1'b0, 2);   endtask
  task automatic exp_dn(input int p);               expect_seg(p, 1'b0, 1'b0, 1'b1, 2);   endtask
  task automatic exp_door(input int p, input int n); expect_seg(p, 1'b1, 1'b0, 1'b0, n);  endtask
  task automatic exp_idle(input int p);             expect_seg(p, 1'b0, 1'b0, 1'b0, 0);   endtask

  task automatic press(input logic [FLOORS-1:0] m);
    @(posedge clk); #1 floor_req = m;
    @(posedge clk); #1 floor_req = '0;
  endtask

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  task automatic close_seg(input logic [5:0] t, input int run);
    seg_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL seg_unexpected: got pos=%0d d/u/dn=%b len=%0d, want none", t[5:3], t[2:0], run);
    end else begin
      e = exp_q.pop_front();
      if (e.tup != t || (e.len != 0 && e.len != run)) begin
        n_bad++;
        $display("FAIL seg: got pos=%0d d/u/dn=%b len=%0d, want pos=%0d d/u/dn=%b len=%0d",
                 t[5:3], t[2:0], run, e.tup[5:3], e.tup[2:0], e.len);
      end
    end
  endtask

  // Monitor: one sample per cycle on the falling edge.
  initial begin
    logic [5:0] cur, prev;
    int run;
    bit have;
    have = 0;
    run  = 0;
    prev = '0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      cur = {floor_pos, door_open, moving_up, moving_down};
      n_cmp++;
      if ((moving_up && moving_down) || (door_open && (moving_up || moving_down))) begin
        n_bad++;
        $display("FAIL excl: got d/u/dn=%b, want at most one high", cur[2:0]);
      end
      if (!have) begin
        prev = cur; run = 1; have = 1;
      end else if (cur == prev) begin
        run++;
      end else begin
        close_seg(prev, run);
        prev = cur; run = 1;
      end
    end
  end

  initial begin
    int hold_len;
`ifdef ELEVATOR_DOOR_HOLD_EN
    hold_len = 5;
`else
    hold_len = 3;
`endif
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pos",  floor_pos,   0);
    check("rst_door", door_open,   0);
    check("rst_up",   moving_up,   0);
    check("rst_down", moving_down, 0);
    check("rst_req",  dut.req_q,   0);
    exp_idle(0);
    rst = 1'b1;

    // Call at the current floor: door only.
    exp_door(0, 3); exp_idle(0);
    press(8'h01);
    repeat (40) @(posedge clk);

    // 0 -> 3
    exp_up(0); exp_up(1); exp_up(2); exp_door(3, 3); exp_idle(3);
    press(8'h08);
    repeat (40) @(posedge clk);

    // 3 -> 1
    exp_dn(3); exp_dn(2); exp_door(1, 3); exp_idle(1);
    press(8'h02);
    repeat (40) @(posedge clk);

    // 1 -> stop at 2 -> 5
    exp_up(1); exp_door(2, 3); exp_up(2); exp_up(3); exp_up(4); exp_door(5, 3); exp_idle(5);
    press(8'h24);
    repeat (40) @(posedge clk);
    #1 check("t31_req_q", dut.req_q, 0);

    // back to 0
    exp_dn(5); exp_dn(4); exp_dn(3); exp_dn(2); exp_dn(1); exp_door(0, 3); exp_idle(0);
    press(8'h01);
    repeat (40) @(posedge clk);

    // 0 -> 5, call 1 pressed while at floor 3: serve 5 then reverse to 1
    exp_up(0); exp_up(1); exp_up(2); exp_up(3); exp_up(4); exp_door(5, 3);
    exp_dn(5); exp_dn(4); exp_dn(3); exp_dn(2); exp_door(1, 3); exp_idle(1);
    press(8'h20);
    repeat (6) @(posedge clk);
    press(8'h02);
    repeat (40) @(posedge clk);

    // Reset during MOVE_UP abandons the call to 4
    exp_up(1); exp_idle(0);
    press(8'h10);
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    check("mr_pos",  floor_pos,   0);
    check("mr_door", door_open,   0);
    check("mr_up",   moving_up,   0);
    check("mr_down", moving_down, 0);
    check("mr_req",  dut.req_q,   0);
    @(posedge clk); #1 rst = 1'b1;
    repeat (10) @(posedge clk);

    // Press of the open-door floor: discarded, or restarts the door with hold
    exp_door(0, hold_len);
    press(8'h01);
    @(posedge clk);
    press(8'h01);
    repeat (20) @(posedge clk);
    #1;
    check("end_queue_empty", exp_q.size(), 0);
    check("end_pos",  floor_pos, 0);
    check("end_door", door_open, 0);
    check("end_req",  dut.req_q, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
